// File: rtl/video_pkg.sv
// Shared types and constants for the test-pattern video stream source.
// Holds the FSM/op encodings, pattern selects and the colour-bar table.
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LGAP   = 2'd2,
        ST_FGAP   = 2'd3
    } state_t;

    // What an accepted beat in ACTIVE does to the raster position
    typedef enum logic [1:0] {
        OP_HOLD      = 2'd0,
        OP_NEXT_PIX  = 2'd1,
        OP_NEXT_LINE = 2'd2,
        OP_END_FRAME = 2'd3
    } op_t;

    localparam logic [7:0] CMODE_ON  = 8'hFF;
    localparam logic [7:0] CMODE_OFF = 8'h00;

    localparam logic [1:0] PAT_SOLID    = 2'd0;
    localparam logic [1:0] PAT_GRADIENT = 2'd1;
    localparam logic [1:0] PAT_BARS     = 2'd2;
    localparam logic [1:0] PAT_CHECKER  = 2'd3;

    // Entries are {B,G,R}; index 0 is the leftmost bar
    localparam logic [0:7][23:0] BAR_TABLE = {
        {CMODE_ON,  CMODE_ON,  CMODE_ON },
        {CMODE_OFF, CMODE_ON,  CMODE_ON },
        {CMODE_ON,  CMODE_ON,  CMODE_OFF},
        {CMODE_OFF, CMODE_ON,  CMODE_OFF},
        {CMODE_ON,  CMODE_OFF, CMODE_ON },
        {CMODE_OFF, CMODE_OFF, CMODE_ON },
        {CMODE_ON,  CMODE_OFF, CMODE_OFF},
        {CMODE_OFF, CMODE_OFF, CMODE_OFF}
    };

    function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern pixel generator, output format 0x00BBGGRR.
module video_pattern_gen
    import video_pkg::*;
(
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [1:0]  mode,
    input  logic [23:0] color,
    output logic [31:0] pixel
);

    // Only the low coordinate bits shape any pattern
    logic unused_bits;
    assign unused_bits = ^{x[11:8], y[11:5], y[3:0]};

    always_comb begin
        pixel = 32'h0;
        case (mode)
            PAT_SOLID:    pixel = {8'h00, color};
            PAT_GRADIENT: pixel = {8'h00, x[7:0], x[7:0], x[7:0]};
            PAT_BARS:     pixel = {8'h00, BAR_TABLE[x[7:5]]};
            PAT_CHECKER:  pixel = (x[4] ^ y[4]) ? 32'h00FF_FFFF : 32'h0;
            default:      pixel = 32'h0;
        endcase
    end

endmodule

// File: rtl/video_stream_source.sv
// Frame-synchronous AXI4-Stream test-pattern source (tuser = SOF, tlast = EOL).
//   state  | meaning
//   IDLE   | waiting for enable with a nonzero frame size
//   ACTIVE | presenting beats of the current frame
//   LGAP   | tvalid low for LINE_GAP cycles between lines
//   FGAP   | tvalid low for FRAME_GAP cycles after the last beat
module video_stream_source
    import video_pkg::*;
#(
    parameter int MAX_WIDTH  = 1280,
    parameter int MAX_HEIGHT = 1024,
    parameter int LINE_GAP   = 0,
    parameter int FRAME_GAP  = 16
) (
    input  logic        m_axis_vid_aclk,
    input  logic        areset,
    input  logic        enable,
    input  logic [11:0] frame_width,
    input  logic [11:0] frame_height,
    input  logic [1:0]  pattern_mode,
    input  logic [23:0] solid_color,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tlast,
    output logic        m_axis_vid_tuser,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam logic [11:0] MAX_W     = 12'(MAX_WIDTH);
    localparam logic [11:0] MAX_H     = 12'(MAX_HEIGHT);
    localparam logic [15:0] LGAP_INIT = (LINE_GAP  > 0) ? 16'(LINE_GAP  - 1) : 16'd0;
    localparam logic [15:0] FGAP_INIT = (FRAME_GAP > 0) ? 16'(FRAME_GAP - 1) : 16'd0;

    state_t      state, state_nx;
    op_t         op;
    logic [11:0] x, y, x_nx, y_nx;
    logic [11:0] w_lat, h_lat, w_cfg, h_cfg, w_use;
    logic [1:0]  mode_lat, pg_mode;
    logic [23:0] color_lat, pg_color;
    logic [15:0] gap_cnt, gap_nx;
    logic [31:0] pixel;
    logic        valid_nx, done_nx, load, start;
    logic        tlast_nx, tuser_nx;

    assign w_cfg = clamp12(frame_width,  MAX_W);
    assign h_cfg = clamp12(frame_height, MAX_H);

    always_comb begin
        op = OP_HOLD;
        if (state == ST_ACTIVE && m_axis_vid_tvalid && m_axis_vid_tready) begin
            if (x != w_lat - 12'd1)
                op = OP_NEXT_PIX;
            else if (y != h_lat - 12'd1)
                op = OP_NEXT_LINE;
            else
                op = OP_END_FRAME;
        end
    end

    always_comb begin
        state_nx = state;
        x_nx     = x;
        y_nx     = y;
        gap_nx   = gap_cnt;
        valid_nx = m_axis_vid_tvalid;
        done_nx  = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && w_cfg != 12'd0 && h_cfg != 12'd0) begin
                    start    = 1'b1;
                    x_nx     = 12'd0;
                    y_nx     = 12'd0;
                    load     = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                case (op)
                    OP_NEXT_PIX: begin
                        x_nx = x + 12'd1;
                        load = 1'b1;
                    end
                    OP_NEXT_LINE: begin
                        x_nx = 12'd0;
                        y_nx = y + 12'd1;
                        if (LINE_GAP > 0) begin
                            valid_nx = 1'b0;
                            gap_nx   = LGAP_INIT;
                            state_nx = ST_LGAP;
                        end else begin
                            load = 1'b1;
                        end
                    end
                    OP_END_FRAME: begin
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                        if (FRAME_GAP > 0) begin
                            gap_nx   = FGAP_INIT;
                            state_nx = ST_FGAP;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
            ST_LGAP: begin
                if (gap_cnt == 16'd0) begin
                    load     = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = ST_ACTIVE;
                end else begin
                    gap_nx = gap_cnt - 16'd1;
                end
            end
            ST_FGAP: begin
                if (gap_cnt == 16'd0)
                    state_nx = ST_IDLE;
                else
                    gap_nx = gap_cnt - 16'd1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // The first beat of a frame must use the live configuration, not the stale latch
    always_comb begin
        pg_mode  = start ? pattern_mode : mode_lat;
        pg_color = start ? solid_color  : color_lat;
        w_use    = start ? w_cfg        : w_lat;
        tlast_nx = (x_nx == w_use - 12'd1);
        tuser_nx = (x_nx == 12'd0) && (y_nx == 12'd0);
    end

    video_pattern_gen u_pattern (
        .x     (x_nx),
        .y     (y_nx),
        .mode  (pg_mode),
        .color (pg_color),
        .pixel (pixel)
    );

    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            state             <= ST_IDLE;
            x                 <= 12'd0;
            y                 <= 12'd0;
            gap_cnt           <= 16'd0;
            w_lat             <= 12'd0;
            h_lat             <= 12'd0;
            mode_lat          <= PAT_SOLID;
            color_lat         <= 24'd0;
            m_axis_vid_tdata  <= 32'd0;
            m_axis_vid_tvalid <= 1'b0;
            m_axis_vid_tlast  <= 1'b0;
            m_axis_vid_tuser  <= 1'b0;
            frame_done        <= 1'b0;
            frame_count       <= 16'd0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nx;
            x                 <= x_nx;
            y                 <= y_nx;
            gap_cnt           <= gap_nx;
            m_axis_vid_tvalid <= valid_nx;
            frame_done        <= done_nx;
            busy              <= (state_nx != ST_IDLE);
            if (done_nx)
                frame_count <= frame_count + 16'd1;
            if (start) begin
                w_lat     <= w_cfg;
                h_lat     <= h_cfg;
                mode_lat  <= pattern_mode;
                color_lat <= solid_color;
            end
            if (load) begin
                m_axis_vid_tdata <= pixel;
                m_axis_vid_tlast <= tlast_nx;
                m_axis_vid_tuser <= tuser_nx;
            end
        end
    end

endmodule

// File: tb/tb_video_stream_source.sv
// Bench for video_stream_source: two instances (default gaps / short gaps with small
// clamp limits), a frame-level reference model and an AXI-Stream hold monitor.
module tb_video_stream_source;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic        enable [2];
    logic [11:0] frame_width, frame_height;
    logic [1:0]  pattern_mode;
    logic [23:0] solid_color;
    logic        tready [2];
    logic [31:0] tdata [2];
    logic        tvalid [2], tlast [2], tuser [2], frame_done [2], busy [2];
    logic [15:0] frame_count [2];

    int checks = 0;
    int failures = 0;
    int done_cnt [2] = '{0, 0};
    int exp_fc [2] = '{0, 0};
    logic [33:0] q0 [$];
    logic [33:0] q1 [$];
    logic        stall_prev [2] = '{1'b0, 1'b0};
    logic        hs_last_prev [2] = '{1'b0, 1'b0};
    logic [34:0] held [2];
    logic        rst_prev = 1'b1;

    video_stream_source dut_a (
        .m_axis_vid_aclk(clk), .areset(areset), .enable(enable[0]),
        .frame_width(frame_width), .frame_height(frame_height),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .m_axis_vid_tdata(tdata[0]), .m_axis_vid_tvalid(tvalid[0]),
        .m_axis_vid_tready(tready[0]), .m_axis_vid_tlast(tlast[0]),
        .m_axis_vid_tuser(tuser[0]), .frame_done(frame_done[0]),
        .frame_count(frame_count[0]), .busy(busy[0]));

    video_stream_source #(.MAX_WIDTH(64), .MAX_HEIGHT(8), .LINE_GAP(3), .FRAME_GAP(5)) dut_b (
        .m_axis_vid_aclk(clk), .areset(areset), .enable(enable[1]),
        .frame_width(frame_width), .frame_height(frame_height),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .m_axis_vid_tdata(tdata[1]), .m_axis_vid_tvalid(tvalid[1]),
        .m_axis_vid_tready(tready[1]), .m_axis_vid_tlast(tlast[1]),
        .m_axis_vid_tuser(tuser[1]), .frame_done(frame_done[1]),
        .frame_count(frame_count[1]), .busy(busy[1]));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int maxw(input int i); return (i == 0) ? 1280 : 64; endfunction
    function automatic int maxh(input int i); return (i == 0) ? 1024 : 8;  endfunction

    // Reference beat {tuser, tlast, tdata} derived directly from the raster position
    function automatic logic [33:0] model_beat(input int x, input int y, input int w,
                                               input int mode, input logic [23:0] color);
        logic [23:0] px;
        int idx;
        case (mode)
            0: px = color;
            1: px = {3{8'(x % 256)}};
            2: begin
                idx = (x % 256) / 32;
                px = {(idx % 2 == 0) ? 8'hFF : 8'h00,
                      (idx < 4) ? 8'hFF : 8'h00,
                      ((idx / 2) % 2 == 0) ? 8'hFF : 8'h00};
            end
            default: px = (((x / 16) % 2) != ((y / 16) % 2)) ? 24'hFFFFFF : 24'h0;
        endcase
        return {(x == 0 && y == 0), (x == w - 1), 8'h00, px};
    endfunction

    function automatic int beat_count(input int i); return (i == 0) ? q0.size() : q1.size(); endfunction
    function automatic logic [33:0] get_beat(input int i, input int k);
        return (i == 0) ? q0[k] : q1[k];
    endfunction
    task automatic clear_q(input int i);
        if (i == 0) q0.delete(); else q1.delete();
    endtask

    // Protocol monitor: capture accepted beats, check stall stability and frame_done timing
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic hs;
            if (stall_prev[i] && !rst_prev)
                check($sformatf("stall_hold_%0d", i),
                      {tvalid[i], tuser[i], tlast[i], tdata[i]}, held[i]);
            if (frame_done[i]) begin
                done_cnt[i]++;
                check($sformatf("done_after_last_%0d", i), hs_last_prev[i], 1'b1);
            end
            hs = tvalid[i] && tready[i] && !areset;
            if (hs && i == 0) q0.push_back({tuser[i], tlast[i], tdata[i]});
            if (hs && i == 1) q1.push_back({tuser[i], tlast[i], tdata[i]});
            hs_last_prev[i] = hs && tlast[i];
            stall_prev[i]   = tvalid[i] && !tready[i];
            held[i]         = {tvalid[i], tuser[i], tlast[i], tdata[i]};
        end
        rst_prev = areset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        exp_fc = '{0, 0};
    endtask

    task automatic compare_frame(input int i, input int w, input int h, input int mode,
                                 input logic [23:0] color);
        int n;
        n = (beat_count(i) < w * h) ? beat_count(i) : w * h;
        for (int k = 0; k < n; k++) begin
            logic [33:0] exp;
            exp = model_beat(k % w, k / w, w, mode, color);
            check($sformatf("beat_%0d_dut%0d", k, i), get_beat(i, k), exp);
            if (get_beat(i, k) !== exp) break;
        end
    endtask

    task automatic finish_frame(input int i, input int d0, input int pct);
        int n;
        n = 0;
        while (done_cnt[i] == d0 && n < 30000) begin
            tready[i] = ($urandom_range(99) < pct);
            tick();
            n++;
        end
        check("frame_timeout", n < 30000, 1'b1);
        tready[i] = 1'b1;
        n = 0;
        while (busy[i] && n < 200) begin
            tick();
            n++;
        end
        check("busy_clears", busy[i], 1'b0);
        exp_fc[i]++;
        check("frame_count", frame_count[i], 16'(exp_fc[i]));
    endtask

    task automatic run_frame(input int i, input int w, input int h, input int mode,
                             input logic [23:0] color, input int pct, input int exp_beats);
        int cw, ch, d0;
        cw = (w > maxw(i)) ? maxw(i) : w;
        ch = (h > maxh(i)) ? maxh(i) : h;
        frame_width  = 12'(w);
        frame_height = 12'(h);
        pattern_mode = 2'(mode);
        solid_color  = color;
        clear_q(i);
        d0 = done_cnt[i];
        check("idle_before_start", {tvalid[i], busy[i]}, 2'b00);
        enable[i] = 1'b1;
        tready[i] = ($urandom_range(99) < pct);
        tick();
        enable[i] = 1'b0;
        check("start_latency", {tvalid[i], tuser[i], busy[i]}, 3'b111);
        finish_frame(i, d0, pct);
        check("beat_count", beat_count(i), exp_beats);
        compare_frame(i, cw, ch, mode, color);
    endtask

    typedef struct {
        int          dut;
        int          w;
        int          h;
        int          mode;
        logic [23:0] color;
        int          pct;
        int          exp_beats;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, zrun;
        logic ok, seen_one;
        logic trace [$];
        int runs [$];

        vecs[0] = '{0, 4, 2, 0, 24'h123456, 100, 8};
        vecs[1] = '{0, 64, 2, 1, 24'h0, 50, 128};
        vecs[2] = '{0, 256, 1, 2, 24'h0, 100, 256};
        vecs[3] = '{0, 40, 40, 3, 24'h0, 70, 1600};
        vecs[4] = '{0, 1, 3, 0, 24'hC0FFEE, 60, 3};
        vecs[5] = '{1, 100, 20, 1, 24'h0, 80, 512};
        vecs[6] = '{1, 2, 2, 2, 24'h0, 100, 4};
        for (int k = 7; k < 11; k++) begin
            int d, w, h, cw, ch;
            d = k % 2;
            w = (d == 0) ? int'($urandom_range(300, 1)) : int'($urandom_range(100, 1));
            h = (d == 0) ? int'($urandom_range(5, 1))   : int'($urandom_range(10, 1));
            cw = (w > maxw(d)) ? maxw(d) : w;
            ch = (h > maxh(d)) ? maxh(d) : h;
            vecs[k] = '{d, w, h, int'($urandom_range(3, 0)), 24'($urandom),
                        int'($urandom_range(100, 30)), cw * ch};
        end

        areset = 1'b1;
        enable = '{1'b0, 1'b0};
        tready = '{1'b1, 1'b1};
        frame_width = 12'd0;
        frame_height = 12'd0;
        pattern_mode = 2'd0;
        solid_color = 24'd0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_tdata", tdata[i], 32'd0);
            check("rst_flags", {tvalid[i], tlast[i], tuser[i], frame_done[i], busy[i]}, 5'd0);
            check("rst_frame_count", frame_count[i], 16'd0);
        end
        areset = 1'b0;
        exp_fc = '{0, 0};

        // Zero width or height never starts a frame
        frame_width = 12'd0; frame_height = 12'd4; enable[0] = 1'b1;
        ok = 1'b1;
        repeat (8) begin tick(); ok &= !busy[0] && !tvalid[0]; end
        check("zero_width_idle", ok, 1'b1);
        frame_width = 12'd4; frame_height = 12'd0;
        ok = 1'b1;
        repeat (8) begin tick(); ok &= !busy[0] && !tvalid[0]; end
        check("zero_height_idle", ok, 1'b1);
        enable[0] = 1'b0;

        for (int k = 0; k < 11; k++) begin
            run_frame(vecs[k].dut, vecs[k].w, vecs[k].h, vecs[k].mode,
                      vecs[k].color, vecs[k].pct, vecs[k].exp_beats);
            if (k == 2 && q0.size() == 256) begin
                check("bars_beat0",   q0[0][31:0],   32'h00FFFFFF);
                check("bars_beat31",  q0[31][31:0],  32'h00FFFFFF);
                check("bars_beat32",  q0[32][31:0],  32'h0000FFFF);
                check("bars_beat255", q0[255][31:0], 32'h00000000);
            end
        end

        // enable drops at beat 10 of 32 and width changes mid-frame
        frame_width = 12'd8; frame_height = 12'd4; pattern_mode = 2'd1;
        tready[0] = 1'b1;
        clear_q(0);
        d0 = done_cnt[0];
        enable[0] = 1'b1;
        n = 0;
        while (q0.size() < 10 && n < 100) begin tick(); n++; end
        enable[0] = 1'b0;
        frame_width = 12'd3;
        pattern_mode = 2'd0;
        solid_color = 24'hABCDEF;
        finish_frame(0, d0, 100);
        check("midframe_beats", q0.size(), 32);
        compare_frame(0, 8, 4, 1, 24'h0);
        ok = 1'b1;
        repeat (20) begin tick(); ok &= !busy[0] && !tvalid[0]; end
        check("stays_idle", ok, 1'b1);
        run_frame(0, 3, 4, 0, 24'hABCDEF, 100, 12);

        // Gap timing on the LINE_GAP=3 / FRAME_GAP=5 instance, two back-to-back frames
        do_reset();
        frame_width = 12'd2; frame_height = 12'd2; pattern_mode = 2'd2;
        clear_q(1);
        tready[1] = 1'b1;
        enable[1] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            trace.push_back(tvalid[1]);
            if (frame_count[1] == 16'd2) enable[1] = 1'b0;
        end
        enable[1] = 1'b0;
        seen_one = 1'b0;
        zrun = 0;
        foreach (trace[c]) begin
            if (trace[c]) begin
                if (seen_one && zrun > 0) runs.push_back(zrun);
                zrun = 0;
                seen_one = 1'b1;
            end else if (seen_one) begin
                zrun++;
            end
        end
        check("gap_run_count", runs.size(), 3);
        if (runs.size() == 3) begin
            check("line_gap_1", runs[0], 3);
            check("frame_gap",  runs[1], 6);
            check("line_gap_2", runs[2], 3);
        end
        check("gap_frames", frame_count[1], 16'd2);
        check("gap_beats", q1.size(), 8);
        check("gap_idle", {busy[1], tvalid[1]}, 2'b00);

        // Reset while a beat is stalled
        frame_width = 12'd16; frame_height = 12'd2; pattern_mode = 2'd3;
        tready[0] = 1'b0;
        enable[0] = 1'b1;
        tick();
        check("stall_valid", {tvalid[0], tuser[0]}, 2'b11);
        repeat (3) tick();
        check("stall_still", {tvalid[0], tuser[0]}, 2'b11);
        areset = 1'b1;
        tick();
        check("rst_mid_flags", {tvalid[0], busy[0], tuser[0], tlast[0]}, 4'd0);
        check("rst_mid_count", frame_count[0], 16'd0);
        check("rst_mid_tdata", tdata[0], 32'd0);
        exp_fc = '{0, 0};
        areset = 1'b0;
        tready[0] = 1'b1;
        clear_q(0);
        d0 = done_cnt[0];
        tick();
        check("restart_tuser", {tvalid[0], tuser[0]}, 2'b11);
        enable[0] = 1'b0;
        finish_frame(0, d0, 100);
        check("restart_beats", q0.size(), 32);
        compare_frame(0, 16, 2, 3, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_stream_source.md
# video_stream_source

Frame-synchronous AXI4-Stream video transmitter: the upstream end of the `m_axis_vid` interface that the scanout block consumes. It generates test-pattern frames, one 32-bit pixel per beat (0x00BBGGRR), with `tuser` on the first beat of each frame and `tlast` on the last beat of each line. It is used for display bring-up without the VDMA and as the stimulus source for scanout benches.

## Interface
Parameters:
- MAX_WIDTH, 1280: largest line length in beats; `frame_width` is clamped to this value.
- MAX_HEIGHT, 1024: largest frame height in lines; `frame_height` is clamped to this value.
- LINE_GAP, 0: idle cycles with `tvalid`=0 inserted after each `tlast` beat, except the last line of a frame.
- FRAME_GAP, 16: idle cycles inserted after the final beat of a frame.

Ports:
- m_axis_vid_aclk  in  1  sole clock.
- areset  in  1  reset; synchronous, active-high.
- enable  in  1  level signal: run frames continuously while high.
- frame_width  in  12  line length in beats; sampled at frame start.
- frame_height  in  12  lines per frame; sampled at frame start.
- pattern_mode  in  2  selects the pattern (see Operation); sampled at frame start.
- solid_color  in  24  colour used by the SOLID pattern, as {B,G,R}; sampled at frame start.
- m_axis_vid_tdata  out  32  pixel value.
- m_axis_vid_tvalid  out  1  beat valid.
- m_axis_vid_tready  in  1  downstream ready.
- m_axis_vid_tlast  out  1  end of line.
- m_axis_vid_tuser  out  1  start of frame.
- frame_done  out  1  one-cycle pulse after the final beat of a frame is accepted.
- frame_count  out  16  number of completed frames; wraps at 16 bits.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACTIVE, LGAP, FGAP.
- IDLE: if `enable`=1 and both `frame_width` and `frame_height` are nonzero:
  - latch the configuration (width and height clamped to the parameters);
  - set x=0, y=0;
  - present the first beat with `tuser`=1;
  - go to ACTIVE.
- IDLE: if width or height is zero, remain in IDLE.
- ACTIVE, on each handshake (`tvalid` & `tready`):
  - Mid-line: advance x.
  - At x=W-1, line is not the last: x=0, y+1. Enter LGAP if LINE_GAP>0; otherwise present the next line's first beat immediately.
  - At x=W-1 and y=H-1: deassert `tvalid`, pulse `frame_done`, increment `frame_count`, enter FGAP.
- LGAP: count LINE_GAP cycles, then return to ACTIVE with `tvalid`=1.
- FGAP: count FRAME_GAP cycles, then go to IDLE. IDLE re-evaluates `enable` in the same cycle as any other IDLE cycle, so back-to-back frames need no extra cycle.
- Stopping: deasserting `enable` mid-frame does not truncate the frame. The frame completes and the block then idles.
- Configuration changes mid-frame are ignored until the next frame start.
- `tuser`=1 only on the beat at x=0, y=0.
- `tlast`=1 only on beats at x=W-1. When W=1, every beat has `tlast`=1, and the first beat also has `tuser`=1.
- Patterns, computed from x, y and the latched configuration:
  - 0 SOLID: {8'h00, solid_color}.
  - 1 GRADIENT: {8'h00, x[7:0], x[7:0], x[7:0]}.
  - 2 BARS: colour index x[7:5] selects white, yellow, cyan, green, magenta, red, blue, black (index 0..7). Each component is 8'hFF or 8'h00.
  - 3 CHECKER: white if x[4]^y[4], otherwise black.
- Widths: x and y are 12 bits and never exceed W-1 / H-1. `frame_count` wraps modulo 2^16.

## Timing
- Reset values: `tvalid`=0, `tlast`=0, `tuser`=0, `tdata`=0, `frame_done`=0, `busy`=0, `frame_count`=0; state is IDLE.
- All outputs are registered.
- Start latency: the first beat is valid 1 cycle after the cycle in which IDLE sees `enable`=1.
- AXI-Stream rules:
  - Once `tvalid`=1, it stays high and `tdata`/`tlast`/`tuser` stay stable until `tready`=1.
  - Output registers load only when `tvalid`=0 or `tready`=1.
  - `tvalid` never depends combinationally on `tready`.
- Throughput: 1 beat per cycle while `tready`=1.
- `frame_done` is high in the cycle after the final handshake.
- FGAP plus the return to IDLE gives exactly FRAME_GAP+1 cycles with `tvalid`=0 between frames.
- Reset asserted mid-frame: all outputs return to their reset values on the next clock edge. No partial-line completion.

## Structure
- Shared package `video_pkg` holds:
  - CMODE_* and OP_* constants;
  - the pattern_mode encodings PAT_SOLID=0, PAT_GRADIENT=1, PAT_BARS=2, PAT_CHECKER=3;
  - the 8-entry colour-bar table.
- One combinational sub-module, `video_pattern_gen`: inputs x, y, mode, colour; output 32-bit pixel.
- The FSM, counters and output register stage stay in the top level.

## Test plan
- W=4, H=2, SOLID 0x123456, `tready`=1: 8 beats, all 0x00123456. `tuser` on beat 0 only; `tlast` on beats 3 and 7; `frame_done` one cycle after beat 7; `frame_count`=1.
- W=64, GRADIENT, random `tready` (50%): beat values 0x00000000..0x003F3F3F in order. Outputs held stable on every stalled cycle, checked by an AXI-Stream protocol checker.
- W=256, BARS, H=1: beats 0 and 31 are 0x00FFFFFF; beat 32 is 0x0000FFFF (yellow); beat 255 is 0x00000000.
- LINE_GAP=3, FRAME_GAP=5, W=2, H=2: exactly 3 `tvalid`-low cycles between lines and 6 between frames; `frame_count` reaches 2 after two frames.
- `enable` drops at mid-frame beat 10 of 32: frame completes, then `busy`=0 and `tvalid` stays 0. Changing width mid-frame has no effect until the next frame.
- Reset asserted while `tvalid`=1 and stalled: next cycle `tvalid`=0, `frame_count`=0, `busy`=0. After release with `enable`=1, the first beat has `tuser`=1.
